// File: rtl/mem_subsystem.sv
// Off-core memory path: request slots + fixed-priority arbiter, registered bus, pipelined line memory.
// Latency: an uncontended read sampled at edge k returns its fill at edge k+MEM_LATENCY+4.
// Backpressure: none; a request whose slot is still occupied is dropped, one slot is forwarded per cycle.
module mem_subsystem #(
  parameter int PADDR_W     = 20,
  parameter int LINE_W      = 128,
  parameter int MEM_LINES   = 4096,
  parameter int MEM_LATENCY = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               icache_req_ren,
  input  logic [PADDR_W-1:0] icache_req_raddr,
  output logic               icache_rec_en,
  output logic [PADDR_W-1:0] icache_rec_addr,
  output logic [LINE_W-1:0]  icache_rec_cacheline,
  input  logic               dcache_req_ren,
  input  logic [PADDR_W-1:0] dcache_req_raddr,
  input  logic               dcache_req_wen,
  input  logic [PADDR_W-1:0] dcache_req_waddr,
  input  logic [LINE_W-1:0]  dcache_req_wcacheline,
  output logic               dcache_rec_en,
  output logic [PADDR_W-1:0] dcache_rec_addr,
  output logic [LINE_W-1:0]  dcache_rec_cacheline
);
  localparam int TAG_W = PADDR_W - 4;
  localparam int IDX_W = $clog2(MEM_LINES);

  // Byte offsets within a line carry no information for a line-granular memory.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{icache_req_raddr[3:0], dcache_req_raddr[3:0], dcache_req_waddr[3:0]};

  // Pending slots: valid, in-flight tag for reads, line tag and write data.
  logic              ir_vld_q, ir_vld_d, ir_fly_q, ir_fly_d;
  logic              dr_vld_q, dr_vld_d, dr_fly_q, dr_fly_d;
  logic              dw_vld_q, dw_vld_d;
  logic [TAG_W-1:0]  ir_tag_q, ir_tag_d, dr_tag_q, dr_tag_d, dw_tag_q, dw_tag_d;
  logic [LINE_W-1:0] dw_dat_q, dw_dat_d;

  // Controller output register, bus request register, memory pipe, bus response register.
  logic              fwd_vld_q, fwd_vld_d, fwd_we_q, fwd_we_d;
  logic [TAG_W-1:0]  fwd_tag_q, fwd_tag_d;
  logic [LINE_W-1:0] fwd_dat_q, fwd_dat_d;
  logic              bus_vld_q, bus_we_q;
  logic [TAG_W-1:0]  bus_tag_q;
  logic [LINE_W-1:0] bus_dat_q;
  logic [MEM_LATENCY-1:0] mem_vld_q;
  logic [TAG_W-1:0]  mem_tag_q [MEM_LATENCY];
  logic [LINE_W-1:0] mem_dat_q [MEM_LATENCY];
  logic              rsp_vld_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic [LINE_W-1:0] rsp_dat_q;

  // Fill output registers.
  logic               ic_en_q, dc_en_q;
  logic [PADDR_W-1:0] ic_addr_q, dc_addr_q;
  logic [LINE_W-1:0]  ic_line_q, dc_line_q;

  logic [LINE_W-1:0] mem_arr [MEM_LINES];
  logic [IDX_W-1:0]  bus_idx;
  logic              sel_ir, sel_dr, sel_dw, ir_hit, dr_hit;

  assign bus_idx = bus_tag_q[IDX_W-1:0];
  assign ir_hit  = rsp_vld_q && ir_vld_q && ir_fly_q && (ir_tag_q == rsp_tag_q);
  assign dr_hit  = rsp_vld_q && dr_vld_q && dr_fly_q && (dr_tag_q == rsp_tag_q);

  // Fixed-priority pick of one waiting slot: D-write, then D-read, then I-read.
  always_comb begin
    fwd_vld_d = 1'b0;
    fwd_we_d  = 1'b0;
    fwd_tag_d = dw_tag_q;
    fwd_dat_d = dw_dat_q;
    sel_dw    = 1'b0;
    sel_dr    = 1'b0;
    sel_ir    = 1'b0;
    if (dw_vld_q) begin
      fwd_vld_d = 1'b1;
      fwd_we_d  = 1'b1;
      sel_dw    = 1'b1;
    end else if (dr_vld_q && !dr_fly_q) begin
      fwd_vld_d = 1'b1;
      fwd_tag_d = dr_tag_q;
      sel_dr    = 1'b1;
    end else if (ir_vld_q && !ir_fly_q) begin
      fwd_vld_d = 1'b1;
      fwd_tag_d = ir_tag_q;
      sel_ir    = 1'b1;
    end
  end

  // Slot next state: forward marks reads in flight, a matching response frees them, a request loads a free slot.
  always_comb begin
    ir_vld_d = ir_vld_q;
    ir_fly_d = ir_fly_q;
    ir_tag_d = ir_tag_q;
    dr_vld_d = dr_vld_q;
    dr_fly_d = dr_fly_q;
    dr_tag_d = dr_tag_q;
    dw_vld_d = dw_vld_q;
    dw_tag_d = dw_tag_q;
    dw_dat_d = dw_dat_q;
    if (sel_ir) ir_fly_d = 1'b1;
    if (sel_dr) dr_fly_d = 1'b1;
    if (sel_dw) dw_vld_d = 1'b0;
    if (ir_hit) begin
      ir_vld_d = 1'b0;
      ir_fly_d = 1'b0;
    end
    if (dr_hit) begin
      dr_vld_d = 1'b0;
      dr_fly_d = 1'b0;
    end
    if (icache_req_ren && !ir_vld_d) begin
      ir_vld_d = 1'b1;
      ir_fly_d = 1'b0;
      ir_tag_d = icache_req_raddr[PADDR_W-1:4];
    end
    if (dcache_req_ren && !dr_vld_d) begin
      dr_vld_d = 1'b1;
      dr_fly_d = 1'b0;
      dr_tag_d = dcache_req_raddr[PADDR_W-1:4];
    end
    if (dcache_req_wen && !dw_vld_d) begin
      dw_vld_d = 1'b1;
      dw_tag_d = dcache_req_waddr[PADDR_W-1:4];
      dw_dat_d = dcache_req_wcacheline;
    end
  end

  // Control state: slot flags, pipeline valids and fill outputs; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_vld_q  <= 1'b0;
      ir_fly_q  <= 1'b0;
      dr_vld_q  <= 1'b0;
      dr_fly_q  <= 1'b0;
      dw_vld_q  <= 1'b0;
      fwd_vld_q <= 1'b0;
      bus_vld_q <= 1'b0;
      mem_vld_q <= '0;
      rsp_vld_q <= 1'b0;
      ic_en_q   <= 1'b0;
      ic_addr_q <= '0;
      ic_line_q <= '0;
      dc_en_q   <= 1'b0;
      dc_addr_q <= '0;
      dc_line_q <= '0;
    end else begin
      ir_vld_q     <= ir_vld_d;
      ir_fly_q     <= ir_fly_d;
      dr_vld_q     <= dr_vld_d;
      dr_fly_q     <= dr_fly_d;
      dw_vld_q     <= dw_vld_d;
      fwd_vld_q    <= fwd_vld_d;
      bus_vld_q    <= fwd_vld_q;
      mem_vld_q[0] <= bus_vld_q && !bus_we_q;
      for (int i = 1; i < MEM_LATENCY; i++) mem_vld_q[i] <= mem_vld_q[i-1];
      rsp_vld_q    <= mem_vld_q[MEM_LATENCY-1];
      ic_en_q      <= ir_hit;
      dc_en_q      <= dr_hit;
      if (ir_hit) begin
        ic_addr_q <= {rsp_tag_q, 4'b0000};
        ic_line_q <= rsp_dat_q;
      end
      if (dr_hit) begin
        dc_addr_q <= {rsp_tag_q, 4'b0000};
        dc_line_q <= rsp_dat_q;
      end
    end
  end

  // Datapath registers; only meaningful when the matching valid is set, so no reset needed.
  always_ff @(posedge clk) begin
    ir_tag_q     <= ir_tag_d;
    dr_tag_q     <= dr_tag_d;
    dw_tag_q     <= dw_tag_d;
    dw_dat_q     <= dw_dat_d;
    fwd_we_q     <= fwd_we_d;
    fwd_tag_q    <= fwd_tag_d;
    fwd_dat_q    <= fwd_dat_d;
    bus_we_q     <= fwd_we_q;
    bus_tag_q    <= fwd_tag_q;
    bus_dat_q    <= fwd_dat_q;
    mem_tag_q[0] <= bus_tag_q;
    mem_dat_q[0] <= mem_arr[bus_idx];
    for (int i = 1; i < MEM_LATENCY; i++) begin
      mem_tag_q[i] <= mem_tag_q[i-1];
      mem_dat_q[i] <= mem_dat_q[i-1];
    end
    rsp_tag_q    <= mem_tag_q[MEM_LATENCY-1];
    rsp_dat_q    <= mem_dat_q[MEM_LATENCY-1];
  end

  // Line array: writes land in the accept cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus_vld_q && bus_we_q) mem_arr[bus_idx] <= bus_dat_q;
  end

  assign icache_rec_en        = ic_en_q;
  assign icache_rec_addr      = ic_addr_q;
  assign icache_rec_cacheline = ic_line_q;
  assign dcache_rec_en        = dc_en_q;
  assign dcache_rec_addr      = dc_addr_q;
  assign dcache_rec_cacheline = dc_line_q;
endmodule

// File: tb/tb_mem_subsystem.sv
// Bench for mem_subsystem: table of isolated reads/writes, then hand-written multi-cycle sequences.
module tb_mem_subsystem;
  logic         clk = 1'b0;
  logic         rst;
  logic         icache_req_ren, dcache_req_ren, dcache_req_wen;
  logic [19:0]  icache_req_raddr, dcache_req_raddr, dcache_req_waddr;
  logic [127:0] dcache_req_wcacheline;
  logic         icache_rec_en, dcache_rec_en;
  logic [19:0]  icache_rec_addr, dcache_rec_addr;
  logic [127:0] icache_rec_cacheline, dcache_rec_cacheline;

  mem_subsystem #(.PADDR_W(20), .LINE_W(128), .MEM_LINES(4096), .MEM_LATENCY(5)) dut (
    .clk(clk), .rst(rst),
    .icache_req_ren(icache_req_ren), .icache_req_raddr(icache_req_raddr),
    .icache_rec_en(icache_rec_en), .icache_rec_addr(icache_rec_addr),
    .icache_rec_cacheline(icache_rec_cacheline),
    .dcache_req_ren(dcache_req_ren), .dcache_req_raddr(dcache_req_raddr),
    .dcache_req_wen(dcache_req_wen), .dcache_req_waddr(dcache_req_waddr),
    .dcache_req_wcacheline(dcache_req_wcacheline),
    .dcache_rec_en(dcache_rec_en), .dcache_rec_addr(dcache_rec_addr),
    .dcache_rec_cacheline(dcache_rec_cacheline)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    bit           d;
    logic [19:0]  addr;
    logic [127:0] data;
  } ev_t;

  typedef struct {
    int           op;    // 0 i-read, 1 d-read, 2 d-write
    logic [19:0]  addr;
    logic [127:0] wdat;
    logic [19:0]  eaddr;
    logic [127:0] edat;
  } vec_t;

  localparam logic [127:0] DB = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [127:0] P1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] P2 = 128'hA5A5_A5A5_0000_FFFF_1234_5678_9ABC_DEF0;
  localparam logic [127:0] P3 = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] P4 = 128'hC0DE_C0DE_0505_0505_CAFE_F00D_5000_0005;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  ev_t evq[$];
  vec_t vec[10];

  // Edge counter plus a log of every fill seen, sampled 1ns after each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (icache_rec_en) evq.push_back('{cyc, 1'b0, icache_rec_addr, icache_rec_cacheline});
    if (dcache_rec_en) evq.push_back('{cyc, 1'b1, dcache_rec_addr, dcache_rec_cacheline});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Present one cycle of requests; 'at' is the edge number that samples them.
  task automatic req(input bit ir, input logic [19:0] ia, input bit dr, input logic [19:0] da,
                     input bit dw, input logic [19:0] wa, input logic [127:0] wd, output int at);
    icache_req_ren        = ir;
    icache_req_raddr      = ia;
    dcache_req_ren        = dr;
    dcache_req_raddr      = da;
    dcache_req_wen        = dw;
    dcache_req_waddr      = wa;
    dcache_req_wcacheline = wd;
    at = cyc + 1;
    tick(1);
    icache_req_ren = 1'b0;
    dcache_req_ren = 1'b0;
    dcache_req_wen = 1'b0;
  endtask

  task automatic find_ev(input string nm, input bit d, input int at,
                         input logic [19:0] a, input logic [127:0] dat);
    int n;
    int k;
    n = 0;
    k = -1;
    foreach (evq[j]) if (evq[j].d == d && evq[j].cyc == at) begin
      n++;
      k = j;
    end
    check({nm, " fill at expected edge"}, n, 1);
    if (k >= 0) begin
      check({nm, " addr"}, evq[k].addr, a);
      check({nm, " data"}, evq[k].data, dat);
    end
  endtask

  task automatic count_ev(input string nm, input bit d, input int exp);
    int n;
    n = 0;
    foreach (evq[j]) if (evq[j].d == d) n++;
    check(nm, n, exp);
  endtask

  initial begin
    int at;
    vec[0] = '{0, 20'h01004, '0, 20'h01000, '0};
    vec[1] = '{2, 20'h0A00C, P1, '0, '0};
    vec[2] = '{1, 20'h0A000, '0, 20'h0A000, P1};
    vec[3] = '{0, 20'h0A008, '0, 20'h0A000, P1};
    vec[4] = '{2, 20'h0B000, P2, '0, '0};
    vec[5] = '{0, 20'h0B00F, '0, 20'h0B000, P2};
    vec[6] = '{1, 20'h4B000, '0, 20'h4B000, P2};  // aliases line index 0xB00
    vec[7] = '{1, 20'hFFFF0, '0, 20'hFFFF0, '0};
    vec[8] = '{2, 20'hFFFFF, P3, '0, '0};
    vec[9] = '{0, 20'hFFFF8, '0, 20'hFFFF0, P3};

    rst = 1'b1;
    icache_req_ren = 1'b0; icache_req_raddr = '0;
    dcache_req_ren = 1'b0; dcache_req_raddr = '0;
    dcache_req_wen = 1'b0; dcache_req_waddr = '0; dcache_req_wcacheline = '0;
    tick(3);
    check("reset icache_rec_en", icache_rec_en, 0);
    check("reset dcache_rec_en", dcache_rec_en, 0);
    check("reset icache_rec_addr", icache_rec_addr, 0);
    check("reset dcache_rec_cacheline", dcache_rec_cacheline, 0);
    rst = 1'b0;
    tick(2);

    // Isolated transactions: fill exactly 9 edges after the request, nothing else.
    for (int v = 0; v < 10; v++) begin
      evq.delete();
      req(vec[v].op == 0, vec[v].addr, vec[v].op == 1, vec[v].addr,
          vec[v].op == 2, vec[v].addr, vec[v].wdat, at);
      tick(14);
      if (vec[v].op == 0) find_ev($sformatf("vec%0d ifill", v), 1'b0, at + 9, vec[v].eaddr, vec[v].edat);
      if (vec[v].op == 1) find_ev($sformatf("vec%0d dfill", v), 1'b1, at + 9, vec[v].eaddr, vec[v].edat);
      count_ev($sformatf("vec%0d icount", v), 1'b0, vec[v].op == 0 ? 1 : 0);
      count_ev($sformatf("vec%0d dcount", v), 1'b1, vec[v].op == 1 ? 1 : 0);
    end

    // Write then read of the same line on the next cycle.
    evq.delete();
    req(0, '0, 0, '0, 1, 20'h02000, DB, at);
    req(0, '0, 1, 20'h02008, 0, '0, '0, at);
    tick(16);
    find_ev("wr-rd dfill", 1'b1, at + 9, 20'h02000, DB);
    count_ev("wr-rd icount", 1'b0, 0);

    // Two reads in one cycle: D-read wins, I-read one cycle later.
    evq.delete();
    req(1, 20'h03000, 1, 20'h04000, 0, '0, '0, at);
    tick(16);
    find_ev("contend dfill", 1'b1, at + 9, 20'h04000, '0);
    find_ev("contend ifill", 1'b0, at + 10, 20'h03000, '0);

    // Both caches on the same line: one response serves both, the second is discarded.
    evq.delete();
    req(1, 20'h07000, 1, 20'h07004, 0, '0, '0, at);
    tick(18);
    find_ev("shared dfill", 1'b1, at + 9, 20'h07000, '0);
    find_ev("shared ifill", 1'b0, at + 9, 20'h07000, '0);
    count_ev("shared icount", 1'b0, 1);
    count_ev("shared dcount", 1'b1, 1);

    // Write, D-read and I-read together: write first, read sees new data.
    evq.delete();
    req(1, 20'h06000, 1, 20'h05000, 1, 20'h05000, P4, at);
    tick(18);
    find_ev("prio dfill", 1'b1, at + 10, 20'h05000, P4);
    find_ev("prio ifill", 1'b0, at + 11, 20'h06000, '0);

    // Reset while a read is in flight; a request during reset is ignored.
    evq.delete();
    req(1, 20'h08000, 0, '0, 0, '0, '0, at);
    tick(3);
    rst = 1'b1;
    dcache_req_ren = 1'b1;
    dcache_req_raddr = 20'h09000;
    tick(2);
    rst = 1'b0;
    dcache_req_ren = 1'b0;
    check("midrst icache_rec_addr", icache_rec_addr, 0);
    check("midrst dcache_rec_cacheline", dcache_rec_cacheline, 0);
    tick(20);
    count_ev("midrst icount", 1'b0, 0);
    count_ev("midrst dcount", 1'b1, 0);

    // After reset: normal latency and memory contents retained.
    evq.delete();
    req(1, 20'h02000, 0, '0, 0, '0, '0, at);
    tick(14);
    find_ev("postrst ifill", 1'b0, at + 9, 20'h02000, DB);
    evq.delete();
    req(0, '0, 1, 20'h05004, 0, '0, '0, at);
    tick(14);
    find_ev("postrst dfill", 1'b1, at + 9, 20'h05000, P4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
